// File: rtl/dma_dsc_splitter.sv
// dma_dsc_splitter: splits a host transfer command into XDMA bypass descriptors,
// none longer than MAX_DSC_LEN bytes and none crossing a MAX_DSC_LEN address boundary.
// Optional statistics counters are built when DMA_DSC_SPLITTER_STATS_EN is defined.
module dma_dsc_splitter #(
  parameter int unsigned MAX_DSC_LEN = 4096
) (
  input  logic        pcie_clk,
  input  logic        pcie_rst,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic [63:0] s_cmd_addr,
  input  logic [31:0] s_cmd_len,
  input  logic        dsc_byp_ready,
  output logic [63:0] dsc_byp_addr,
  output logic [31:0] dsc_byp_len,
  output logic        dsc_byp_load,
  output logic        cmd_done,
  output logic        busy,
  output logic [31:0] stat_cmd_cnt,
  output logic [31:0] stat_dsc_cnt
);

  localparam int unsigned OFF_W = $clog2(MAX_DSC_LEN);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t      state;
  logic [63:0] addr_r;
  logic [31:0] rem_r;
  logic [31:0] offset;
  logic [31:0] room;
  logic [31:0] chunk;
  logic        accept;
  logic        load;
  logic        last;

  // Descriptor length: remaining bytes, clipped at the next MAX_DSC_LEN boundary.
  always_comb begin
    offset = '0;
    offset[OFF_W-1:0] = addr_r[OFF_W-1:0];
    room   = 32'(MAX_DSC_LEN) - offset;
    chunk  = (rem_r < room) ? rem_r : room;
  end

  assign s_cmd_ready  = (state == IDLE);
  assign accept       = s_cmd_valid & s_cmd_ready;
  // Gated by reset so no descriptor is loaded while the block is being reset.
  assign load         = (state == ISSUE) & dsc_byp_ready & ~pcie_rst;
  assign last         = (chunk == rem_r);
  assign dsc_byp_load = load;
  assign dsc_byp_addr = addr_r;
  assign dsc_byp_len  = chunk;
  assign busy         = (state == ISSUE);

  // Command FSM: latch a command, then walk it one descriptor per load.
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      state    <= IDLE;
      addr_r   <= '0;
      rem_r    <= '0;
      cmd_done <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_r <= s_cmd_addr;
            rem_r  <= s_cmd_len;
            if (s_cmd_len == '0) cmd_done <= 1'b1;
            else                 state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (load) begin
            addr_r <= addr_r + {32'd0, chunk};
            rem_r  <= rem_r - chunk;
            if (last) begin
              state    <= IDLE;
              cmd_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMA_DSC_SPLITTER_STATS_EN
  logic [31:0] cmd_cnt_r;
  logic [31:0] dsc_cnt_r;

  // Statistics: accepted commands (zero-length included) and loaded descriptors.
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      cmd_cnt_r <= '0;
      dsc_cnt_r <= '0;
    end else begin
      if (accept) cmd_cnt_r <= cmd_cnt_r + 32'd1;
      if (load)   dsc_cnt_r <= dsc_cnt_r + 32'd1;
    end
  end

  assign stat_cmd_cnt = cmd_cnt_r;
  assign stat_dsc_cnt = dsc_cnt_r;
`else
  assign stat_cmd_cnt = '0;
  assign stat_dsc_cnt = '0;
`endif

endmodule
